// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone RAM arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  localparam int unsigned MST_VIDEO_IN  = 0;
  localparam int unsigned MST_VIDEO_OUT = 1;
  localparam int unsigned MST_CPU       = 2;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational winner selection: real-time master first, otherwise round-robin
// starting just after the previous owner.
module wb_arb_rr_pick #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned RT_MASTER   = 1,
  parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDX_W-1:0]       pick_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    cand     = '0;
    if (req[RT_MASTER]) begin
      pick[RT_MASTER] = 1'b1;
      pick_idx        = IDX_W'(RT_MASTER);
    end else begin
      // Walk from the farthest candidate inwards so the nearest requester wins.
      for (int unsigned i = NUM_MASTERS; i >= 1; i--) begin
        cand = IDX_W'((32'(last_grant) + i) % NUM_MASTERS);
        if (req[cand]) begin
          pick       = '0;
          pick[cand] = 1'b1;
          pick_idx   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares one Wishbone RAM slave between several masters with real-time priority,
// round-robin fairness and bounded grant length. WB_ARB_TIMEOUT_EN adds a stall timeout.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned RT_MASTER      = MST_VIDEO_OUT,
  parameter int unsigned MAX_GRANT      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                p_clk,
  input  logic                                p_resetn,
  input  logic [NUM_MASTERS-1:0]              m_wb_CYC_I,
  input  logic [NUM_MASTERS-1:0]              m_wb_STB_I,
  input  logic [NUM_MASTERS-1:0]              m_wb_WE_I,
  input  logic [NUM_MASTERS-1:0]              m_wb_LOCK_I,
  input  logic [NUM_MASTERS-1:0][ADR_W-1:0]   m_wb_ADR_I,
  input  logic [NUM_MASTERS-1:0][DAT_W-1:0]   m_wb_DAT_I,
  input  logic [NUM_MASTERS-1:0][SEL_W-1:0]   m_wb_SEL_I,
  output logic [DAT_W-1:0]                    m_wb_DAT_O,
  output logic [NUM_MASTERS-1:0]              m_wb_ACK_O,
  output logic [NUM_MASTERS-1:0]              m_wb_ERR_O,
  output logic [NUM_MASTERS-1:0]              m_wb_RTY_O,
  output logic                                s_wb_CYC_O,
  output logic                                s_wb_STB_O,
  output logic                                s_wb_WE_O,
  output logic                                s_wb_LOCK_O,
  output logic [ADR_W-1:0]                    s_wb_ADR_O,
  output logic [DAT_W-1:0]                    s_wb_DAT_O,
  output logic [SEL_W-1:0]                    s_wb_SEL_O,
  input  logic [DAT_W-1:0]                    s_wb_DAT_I,
  input  logic                                s_wb_ACK_I,
  input  logic                                s_wb_ERR_I,
  input  logic                                s_wb_RTY_I,
  output logic [NUM_MASTERS-1:0]              grant_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
  localparam int unsigned BEAT_W = $clog2(MAX_GRANT + 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || RT_MASTER >= NUM_MASTERS || MAX_GRANT < 1 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("wb_ram_arbiter: illegal parameter set");
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   in_grant, others, preempt, bus_on, timeout_fire;

  wb_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .RT_MASTER  (RT_MASTER),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req       (m_wb_CYC_I),
    .last_grant(last_grant_q),
    .pick      (pick),
    .pick_idx  (pick_idx)
  );

  assign in_grant = (state_q == ARB_GRANT);
  assign others   = |(m_wb_CYC_I & ~grant_q);
  // Preemption blanks the bus in its decision cycle so the owner cannot finish one more beat.
  assign preempt  = in_grant && (beat_q == BEAT_W'(MAX_GRANT)) && others &&
                    !m_wb_LOCK_I[last_grant_q];
  assign bus_on   = in_grant && !preempt;

  assign m_wb_DAT_O = s_wb_DAT_I;
  assign grant_o    = in_grant ? grant_q : '0;

  always_comb begin
    s_wb_CYC_O  = 1'b0;
    s_wb_STB_O  = 1'b0;
    s_wb_WE_O   = 1'b0;
    s_wb_LOCK_O = 1'b0;
    s_wb_ADR_O  = '0;
    s_wb_DAT_O  = '0;
    s_wb_SEL_O  = '0;
    m_wb_ACK_O  = '0;
    m_wb_ERR_O  = '0;
    m_wb_RTY_O  = '0;
    if (bus_on) begin
      s_wb_CYC_O                 = m_wb_CYC_I[last_grant_q];
      s_wb_STB_O                 = m_wb_CYC_I[last_grant_q] & m_wb_STB_I[last_grant_q];
      s_wb_WE_O                  = m_wb_WE_I[last_grant_q];
      s_wb_LOCK_O                = m_wb_LOCK_I[last_grant_q];
      s_wb_ADR_O                 = m_wb_ADR_I[last_grant_q];
      s_wb_DAT_O                 = m_wb_DAT_I[last_grant_q];
      s_wb_SEL_O                 = m_wb_SEL_I[last_grant_q];
      m_wb_ACK_O[last_grant_q]   = s_wb_ACK_I;
      m_wb_ERR_O[last_grant_q]   = s_wb_ERR_I | timeout_fire;
      m_wb_RTY_O[last_grant_q]   = s_wb_RTY_I;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|m_wb_CYC_I) begin
          grant_d      = pick;
          last_grant_d = pick_idx;
          state_d      = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (bus_on && s_wb_ACK_I && beat_q != BEAT_W'(MAX_GRANT)) begin
          beat_d = beat_q + BEAT_W'(1);
        end
        if (timeout_fire || !m_wb_CYC_I[last_grant_q] || preempt) begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        grant_d = '0;
        beat_d  = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               resp;

  assign resp         = s_wb_ACK_I | s_wb_ERR_I | s_wb_RTY_I;
  assign timeout_fire = s_wb_STB_O && !resp && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_d = stall_q;
    if (!in_grant || resp) begin
      stall_d = '0;
    end else if (s_wb_STB_O) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

endmodule
